execute_muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit for the execute stage, parametrised in operand width. It accepts an operand pair and an M-extension operation from the execute operand selector after forwarding. It computes the result over multiple cycles and stalls the pipeline until the result is ready. The ALU path is unaffected; the execute stage muxes this unit's result onto `alu_data` when `out_valid` is high.

---
 rtl/common.sv | 32 +++
 rtl/muldiv_sign_fix.sv | 13 +
 rtl/execute_muldiv_unit.sv | 207 ++++++++++++++++++++
 tb/tb_execute_muldiv_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared execute-stage types: M-extension op codes, mul/div FSM states and
// the decoded control bundle.
package common;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_t;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
        logic alu_src;
        logic is_muldiv;
    } control_type;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate: magnitude of a signed operand on the
// way in, sign restore of a product/quotient/remainder on the way out.
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         neg,
    output logic [W-1:0] result
);

    assign result = neg ? (~value + W'(1)) : value;

endmodule

// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M multiply/divide for EX: shift-add multiply and restoring
// divide on magnitudes, one bit per cycle, stalling the pipe until done.
module execute_muldiv_unit
    import common::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    input  md_op_t          md_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [XLEN-1:0] MIN_NEG =
        {1'b1, {(XLEN-1){1'b0}}};

    md_state_t        state_q;
    md_state_t        state_d;
    md_op_t           op_q;
    logic             a_neg_q;
    logic             b_neg_q;
    logic [XLEN-1:0]  b_q;
    logic [XLEN-1:0]  hi_q;
    logic [XLEN-1:0]  lo_q;
    logic [XLEN-1:0]  hi_d;
    logic [XLEN-1:0]  lo_d;
    logic [CNT_W-1:0] cnt_q;
    logic             out_valid_q;
    logic [XLEN-1:0]  result_q;

    logic             is_div;
    logic             signed_a;
    logic             signed_b;
    logic             a_neg;
    logic             b_neg;
    logic             div_zero;
    logic             div_ovf;
    logic             fast;
    logic             accept;
    logic             last_iter;
    logic [XLEN-1:0]  mag_a;
    logic [XLEN-1:0]  mag_b;
    logic [XLEN-1:0]  fast_res;
    logic [XLEN-1:0]  calc_res;

    logic [XLEN:0]    mul_sum;
    logic [XLEN:0]    div_sh;
    logic [XLEN:0]    div_diff;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]  quo;
    logic [XLEN-1:0]  rem;

    assign is_div   = md_op inside {DIV, DIVU, REM, REMU};
    assign signed_a = md_op inside {MULH, MULHSU, DIV, REM};
    assign signed_b = md_op inside {MULH, DIV, REM};
    assign a_neg    = signed_a & op_a[XLEN-1];
    assign b_neg    = signed_b & op_b[XLEN-1];

    assign div_zero = is_div & (op_b == '0);
    assign div_ovf  = (md_op inside {DIV, REM})
                    & (op_a == MIN_NEG)
                    & (op_b == '1);
    assign fast     = div_zero | div_ovf;
    assign accept   = in_valid & ~flush;
    assign last_iter = (cnt_q == CNT_W'(XLEN - 1));

    muldiv_sign_fix #(.W(XLEN)) u_fix_a (
        .value  (op_a),
        .neg    (a_neg),
        .result (mag_a)
    );

    muldiv_sign_fix #(.W(XLEN)) u_fix_b (
        .value  (op_b),
        .neg    (b_neg),
        .result (mag_b)
    );

    always_comb begin
        fast_res = '0;
        if (div_zero) begin
            fast_res = (md_op inside {DIV, DIVU}) ? '1 : op_a;
        end else if (div_ovf) begin
            fast_res = (md_op == DIV) ? op_a : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = fast ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    // hi:lo is the product accumulator or the remainder:quotient pair
    always_comb begin
        mul_sum  = {1'b0, hi_q}
                 + (lo_q[0] ? {1'b0, b_q} : '0);
        div_sh   = {hi_q, lo_q[XLEN-1]};
        div_diff = div_sh - {1'b0, b_q};
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (op_q[2]) begin
            if (!div_diff[XLEN]) begin
                hi_d = div_diff[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_d = div_sh[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    muldiv_sign_fix #(.W(2*XLEN)) u_fix_prod (
        .value  ({hi_d, lo_d}),
        .neg    (a_neg_q ^ b_neg_q),
        .result (prod)
    );

    muldiv_sign_fix #(.W(XLEN)) u_fix_quo (
        .value  (lo_d),
        .neg    (a_neg_q ^ b_neg_q),
        .result (quo)
    );

    muldiv_sign_fix #(.W(XLEN)) u_fix_rem (
        .value  (hi_d),
        .neg    (a_neg_q),
        .result (rem)
    );

    always_comb begin
        calc_res = '0;
        unique case (op_q)
            MUL:                  calc_res = prod[XLEN-1:0];
            MULH, MULHSU, MULHU:  calc_res = prod[2*XLEN-1:XLEN];
            DIV, DIVU:            calc_res = quo;
            REM, REMU:            calc_res = rem;
            default:              calc_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            op_q        <= MUL;
            a_neg_q     <= 1'b0;
            b_neg_q     <= 1'b0;
            b_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d == DONE);
            if (state_d == DONE) begin
                result_q <= (state_q == IDLE) ? fast_res : calc_res;
            end
            if (state_q == IDLE && accept) begin
                op_q    <= md_op;
                a_neg_q <= a_neg;
                b_neg_q <= b_neg;
                b_q     <= mag_b;
                hi_q    <= '0;
                lo_q    <= mag_a;
                cnt_q   <= '0;
            end else if (state_q == CALC) begin
                hi_q  <= hi_d;
                lo_q  <= lo_d;
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall     = in_valid & ~out_valid_q & ~flush;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = (state_q == CALC);

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Scoreboard bench for execute_muldiv_unit: random and directed RV32M ops
// against a plain-arithmetic reference, plus flush and reset scenarios.
module tb_execute_muldiv_unit;
    import common::*;

    localparam int XLEN = 32;

    logic            clk      = 1'b0;
    logic            reset_n  = 1'b0;
    logic            in_valid = 1'b0;
    logic            flush    = 1'b0;
    md_op_t          md_op    = MUL;
    logic [XLEN-1:0] op_a     = '0;
    logic [XLEN-1:0] op_b     = '0;
    logic            stall;
    logic            out_valid;
    logic [XLEN-1:0] result;
    logic            busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] res;
        int          due;
        md_op_t      op;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] last_res = '0;

    execute_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .md_op     (md_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .stall     (stall),
        .out_valid (out_valid),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_md(md_op_t op, logic [31:0] a,
                                           logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb2 = longint'($signed(b));
        longint      ua = longint'({32'b0, a});
        longint      ub = longint'({32'b0, b});
        logic [63:0] p;
        case (op)
            MUL:    begin p = ua * ub;  return p[31:0];  end
            MULH:   begin p = sa * sb2; return p[63:32]; end
            MULHSU: begin p = sa * ub;  return p[63:32]; end
            MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = sa / sb2; return p[31:0];
            end
            REM:    begin
                if (b == 0) return a;
                p = sa % sb2; return p[31:0];
            end
            DIVU:   begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic bit is_fast(md_op_t op, logic [31:0] a,
                                   logic [31:0] b);
        bit ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        return (op inside {DIV, DIVU, REM, REMU} && b == 0)
            || (op inside {DIV, REM} && ovf);
    endfunction

    // Called just after a rising edge; returns just after the edge that
    // follows the DONE cycle, with in_valid low.
    task automatic issue(md_op_t op, logic [31:0] a, logic [31:0] b);
        int lat;
        int n;
        bit done;
        lat      = is_fast(op, a, b) ? 1 : XLEN + 1;
        in_valid = 1'b1;
        md_op    = op;
        op_a     = a;
        op_b     = b;
        last_res = ref_md(op, a, b);
        sb.push_back('{last_res, cyc + lat, op});
        n    = 0;
        done = 1'b0;
        for (int k = 0; k < XLEN + 8 && !done; k++) begin
            @(negedge clk);
            if (stall) n++;
            else done = 1'b1;
        end
        check("stall_cycles", 64'(n), 64'(lat));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out_valid got=%h exp=none",
                         result);
            end else begin
                e = sb.pop_front();
                check($sformatf("result_op%0d", e.op), 64'(result),
                      64'(e.res));
                check("latency", 64'(cyc), 64'(e.due));
            end
        end
    end

    // EX must hold its instruction while the unit is working
    always @(negedge clk) begin
        if (reset_n && (busy || out_valid) && !flush && !in_valid) begin
            checks++;
            failures++;
            $display("FAIL in_valid_drop got=0 exp=1");
        end
    end

    initial begin
        md_op_t      rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        issue(MUL, 32'd7, 32'hFFFF_FFFD);
        issue(MULH, 32'h8000_0000, 32'h8000_0000);
        issue(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        issue(REM, 32'hFFFF_FFF9, 32'd2);
        issue(DIVU, 32'd100, 32'd7);
        issue(REMU, 32'd100, 32'd7);
        issue(DIV, 32'd5, 32'd0);
        issue(REM, 32'd5, 32'd0);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(REM, 32'h8000_0000, 32'hFFFF_FFFF);

        // abort mid-calculation
        in_valid = 1'b1;
        md_op    = DIVU;
        op_a     = 32'd1000;
        op_b     = 32'd7;
        repeat (11) @(posedge clk);
        #1;
        check("busy_before_flush", 64'(busy), 64'd1);
        flush    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("busy_after_flush", 64'(busy), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check("result_kept", 64'(result), 64'(last_res));
        issue(DIVU, 32'd9, 32'd3);

        // flush and accept together: nothing starts
        in_valid = 1'b1;
        flush    = 1'b1;
        md_op    = MUL;
        op_a     = 32'd3;
        op_b     = 32'd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_accept_busy", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("flush_accept_result", 64'(result), 64'(last_res));

        // asynchronous reset in the middle of CALC
        in_valid = 1'b1;
        md_op    = MUL;
        op_a     = 32'd5;
        op_b     = 32'd6;
        repeat (6) @(posedge clk);
        #3;
        check("busy_before_reset", 64'(busy), 64'd1);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        #1;
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_result", 64'(result), 64'd0);
        check("async_busy", 64'(busy), 64'd0);
        check("async_stall", 64'(stall), 64'd0);
        last_res = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        issue(MUL, 32'd2, 32'd3);

        for (int i = 0; i < 24; i++) begin
            rop = md_op_t'(3'($urandom_range(0, 7)));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end else if (sel == 2) rb = $urandom_range(1, 15);
            else if (sel == 3) rb = -$urandom_range(1, 15);
            issue(rop, ra, rb);
        end

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
